special_split_sync: RTL and testbench



---
 rtl/special_split_sync_if.sv | 21 ++
 rtl/special_split_sync.sv | 76 +++++++
 tb/tb_special_split_sync.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/special_split_sync_if.sv
// Valid/ready token channel shared by the splitter's input and both outputs.
// The master drives valid/data; the slave drives ready.
interface special_split_sync_if #(
  parameter int WIDTH = 1
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/special_split_sync.sv
// Two-output NoC token splitter: one input buffer, one buffer per output.
// The token's select bit picks the output; the token is forwarded unchanged.
module special_split_sync #(
  parameter int WIDTH   = 1,
  parameter int SEL_BIT = 0
) (
  input  logic clk,
  input  logic reset,
  special_split_sync_if.slave  in_ch,
  special_split_sync_if.master out0,
  special_split_sync_if.master out1
);

  typedef struct packed {
    logic             full;
    logic [WIDTH-1:0] data;
  } buf_t;

  buf_t in_buf;
  buf_t out0_buf;
  buf_t out1_buf;

  logic target;
  logic out0_fire;
  logic out1_fire;
  logic route_fire;
  logic in_fire;
  logic load0;
  logic load1;

  assign target    = in_buf.data[SEL_BIT];
  assign out0_fire = out0_buf.full && out0.ready;
  assign out1_fire = out1_buf.full && out1.ready;

  // A full output buffer still accepts if it drains on the same edge.
  assign route_fire = in_buf.full &&
    (target ? (!out1_buf.full || out1_fire)
            : (!out0_buf.full || out0_fire));

  assign in_ch.ready = !in_buf.full || route_fire;
  assign in_fire     = in_ch.valid && in_ch.ready;
  assign load0       = route_fire && !target;
  assign load1       = route_fire && target;

  assign out0.valid = out0_buf.full;
  assign out0.data  = out0_buf.data;
  assign out1.valid = out1_buf.full;
  assign out1.data  = out1_buf.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_buf   <= '0;
      out0_buf <= '0;
      out1_buf <= '0;
    end else begin
      if (in_fire) begin
        in_buf <= {1'b1, in_ch.data};
      end else if (route_fire) begin
        in_buf.full <= 1'b0;
      end

      if (load0) begin
        out0_buf <= {1'b1, in_buf.data};
      end else if (out0_fire) begin
        out0_buf.full <= 1'b0;
      end

      if (load1) begin
        out1_buf <= {1'b1, in_buf.data};
      end else if (out1_fire) begin
        out1_buf.full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_special_split_sync.sv
// Scoreboard bench for special_split_sync (WIDTH=9, SEL_BIT=8).
// Drivers push expected tokens per output; a monitor pops and compares.
module tb_special_split_sync;

  localparam int W = 9;

  logic clk;
  logic reset;

  special_split_sync_if #(.WIDTH(W)) in_if ();
  special_split_sync_if #(.WIDTH(W)) o0_if ();
  special_split_sync_if #(.WIDTH(W)) o1_if ();

  special_split_sync #(
    .WIDTH   (W),
    .SEL_BIT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in_ch (in_if),
    .out0  (o0_if),
    .out1  (o1_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];
  int checks   = 0;
  int errors   = 0;
  int accepted = 0;
  int emitted  = 0;
  bit rnd_on   = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer at the next rising edge is visible here.
  always @(negedge clk) begin
    if (!reset) begin
      if (o0_if.valid && o0_if.ready) begin
        emitted++;
        if (exp0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out0_extra: got %h expected none", o0_if.data);
        end else begin
          chk("out0_data", o0_if.data, exp0.pop_front());
        end
      end
      if (o1_if.valid && o1_if.ready) begin
        emitted++;
        if (exp1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out1_extra: got %h expected none", o1_if.data);
        end else begin
          chk("out1_data", o1_if.data, exp1.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, output int waited);
    int n;
    n = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    @(negedge clk);
    while (!in_if.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!in_if.ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else begin
      accepted++;
      if (d[8]) exp1.push_back(d);
      else      exp0.push_back(d);
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               exp0.size() + exp1.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Random per-cycle backpressure while rnd_on is set.
  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      o0_if.ready = 1'($urandom_range(0, 1));
      o1_if.ready = 1'($urandom_range(0, 1));
    end
  end

  logic [W-1:0] stream [5];
  int w;

  initial begin
    reset       = 1'b1;
    in_if.valid = 1'b0;
    in_if.data  = '0;
    o0_if.ready = 1'b1;
    o1_if.ready = 1'b1;
    #1;
    chk("rst_in_ready", 9'(in_if.ready), 9'd1);
    chk("rst_out0_valid", 9'(o0_if.valid), 9'd0);
    chk("rst_out1_valid", 9'(o1_if.valid), 9'd0);
    chk("rst_out0_data", o0_if.data, 9'h000);
    chk("rst_out1_data", o1_if.data, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Two-cycle latency to out0.
    send(9'h000, w);
    chk("lat_n_out0_valid", 9'(o0_if.valid), 9'd0);
    @(posedge clk);
    #1;
    chk("lat_n1_out0_valid", 9'(o0_if.valid), 9'd1);
    chk("lat_n1_out0_data", o0_if.data, 9'h000);
    chk("lat_n1_out1_valid", 9'(o1_if.valid), 9'd0);
    drain();

    // Mixed-target stream at one token per cycle.
    stream[0] = 9'h101;
    stream[1] = 9'h002;
    stream[2] = 9'h103;
    stream[3] = 9'h104;
    stream[4] = 9'h005;
    foreach (stream[i]) begin
      send(stream[i], w);
      chk("stream_no_stall", 9'(w), 9'd0);
    end
    drain();

    // Backpressure on out1 blocks the out0 token behind it.
    o1_if.ready = 1'b0;
    send(9'h111, w);
    send(9'h122, w);
    in_if.valid = 1'b1;
    in_if.data  = 9'h033;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 9'(in_if.ready), 9'd0);
      chk("bp_out0_valid", 9'(o0_if.valid), 9'd0);
    end
    @(posedge clk);
    #1;
    o1_if.ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 9'(in_if.ready), 9'd1);
    if (in_if.ready) begin
      accepted++;
      exp0.push_back(9'h033);
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    drain();

    // Random stream under random backpressure.
    rnd_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(9'($urandom_range(0, 511)), w);
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    o0_if.ready = 1'b1;
    o1_if.ready = 1'b1;
    drain();
    chk("count_out_eq_in", 9'(emitted - accepted), 9'd0);

    // Asynchronous reset with every buffer full.
    o0_if.ready = 1'b0;
    o1_if.ready = 1'b0;
    send(9'h1AA, w);
    send(9'h0BB, w);
    send(9'h1CC, w);
    @(posedge clk);
    #1;
    chk("full_out0_valid", 9'(o0_if.valid), 9'd1);
    chk("full_out1_valid", 9'(o1_if.valid), 9'd1);
    chk("full_in_ready", 9'(in_if.ready), 9'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out0_valid", 9'(o0_if.valid), 9'd0);
    chk("arst_out1_valid", 9'(o1_if.valid), 9'd0);
    chk("arst_in_ready", 9'(in_if.ready), 9'd1);
    chk("arst_out0_data", o0_if.data, 9'h000);
    chk("arst_out1_data", o1_if.data, 9'h000);
    accepted = accepted - 3;
    exp0.delete();
    exp1.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    o0_if.ready = 1'b1;
    o1_if.ready = 1'b1;

    // Wide token, select on the top bit.
    send(9'h1A5, w);
    send(9'h0A5, w);
    drain();
    chk("final_count", 9'(emitted - accepted), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
